pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator: measures high time and period of an incoming PWM waveform in clk cycles.
- Publishes one (ton, period) pair per complete PWM cycle, with a one-cycle valid strobe.
- Flags loss of signal when the input sits at a constant level (0% or 100% duty, or line dead).
- Used to close the loop on breathing/duty-sweep outputs and to decode PWM from external sources.

Parameters:
- CNT_W, 16, width of all cycle counters and of the ton/period outputs.
- SYNC_STAGES, 2, number of synchronizer flops on pwm_in; legal range 2..4.
- TIMEOUT, 1000, cycles without a rising edge before no_signal is declared. Must satisfy 2 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous, active-high reset.
- pwm_in, input, 1, asynchronous PWM waveform under measurement.
- ton, output, CNT_W, high time of the last complete PWM cycle, in clk cycles.
- period, output, CNT_W, rising-to-rising length of the last complete PWM cycle, in clk cycles.
- valid, output, 1, one-cycle strobe; ton and period were updated on this cycle.
- no_signal, output, 1, high while the input has stalled or no full cycle has yet been measured.
- level, output, 1, synchronized pwm_in; meaningful as stuck level when no_signal=1.

Behaviour:
- Reset (async assert, sync-style deassert to clk is the integrator's job):
  - ton=0, period=0, valid=0, no_signal=1, level=0.
  - All sync flops 0, cnt=0, hi_cnt=0, state=IDLE.
- Synchronizer and edge detect:
  - pwm_in passes through SYNC_STAGES flops; s = last stage; p = s delayed one cycle.
  - rise = s & ~p; fall = ~s & p.
  - Edge E is the first clk edge at which stage 1 captures the new level; outputs driven by that event update on edge E+SYNC_STAGES.
- Counter cnt:
  - Loaded with 1 on the cycle a rise is detected, otherwise increments by 1.
  - Holds at TIMEOUT and never wraps.
  - When any edge is detected, cnt equals the number of cycles since the previous rise detect.
- State machine states: IDLE, ARMED_HI, HIGH, LOW.
  - IDLE: wait for rise -> ARMED_HI. Falls are ignored.
  - ARMED_HI (first high phase after IDLE): on fall, hi_cnt<=cnt -> LOW. No publish yet.
  - LOW: on rise, publish ton<=hi_cnt, period<=cnt, valid=1, no_signal<=0 -> HIGH.
  - HIGH: on fall, hi_cnt<=cnt -> LOW.
- Timeout:
  - In any non-IDLE state, if cnt==TIMEOUT and no edge is detected that cycle, go to IDLE and set no_signal<=1.
  - ton and period hold their last values; valid is not pulsed.
  - An edge in the same cycle as reaching TIMEOUT wins; no timeout occurs.
- Exiting no_signal: no_signal clears only with the first publish after a full measured cycle, i.e. the second rise after IDLE.
- level: level = s, registered copy, updated every cycle.
- Width and range rules:
  - Minimum measurable pulse is 1 cycle at both levels.
  - Period >= 2 is guaranteed by the synchronizer.
  - Periods >= TIMEOUT are reported as no_signal, never as a truncated value.
- Reset mid-measurement: abandons the partial cycle. No valid is issued until a full cycle completes after release.
- valid is never high on two consecutive cycles; minimum spacing equals the measured period.

Decomposition:
- Shared package pwm_pkg:
  - State encoding (IDLE, ARMED_HI, HIGH, LOW).
  - Default CNT_W.
  - Same period/width constants the PWM generator uses, so both ends agree.
- One sub-module, pwm_sync_edge: SYNC_STAGES-deep synchronizer plus rise/fall detect, outputs s/rise/fall. It is reusable for other asynchronous inputs.
- Counter, FSM and output registers stay in pwm_capture.

Test Plan:
- Steady PWM, 10 cycles high / 40 low, repeated 5 times:
  - no_signal stays 1 through the first cycle.
  - Then valid fires exactly every 50 cycles with ton=10, period=50.
  - no_signal drops on the first valid.
- Duty sweep matching the generator (ton 0,5,10..45 of period 50): each published ton equals the driven high time and period=50. The ton=0 segment yields no rises, giving no_signal=1 after TIMEOUT with level=0.
- Stall at TIMEOUT=200:
  - Drive 10/40 twice, then hold high.
  - no_signal rises exactly 200 cycles after the last rise detect with level=1.
  - ton=10 and period=50 hold; no further valid.
- Boundary:
  - Minimum waveform 1 high / 1 low gives ton=1, period=2 every 2 cycles.
  - A rise landing exactly when cnt reaches TIMEOUT publishes normally, with no no_signal.
- Reset mid-operation: assert rst during a high phase of 10/40.
  - All outputs return to reset values immediately (async).
  - After release, the first valid appears only after a full rise-to-rise cycle, with correct values.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair, so both ends agree
// on counter width, nominal period and duty step.
package pwm_pkg;

    localparam int PWM_CNT_W     = 16;
    localparam int PWM_PERIOD    = 50;
    localparam int PWM_DUTY_STEP = 5;
    localparam int PWM_TIMEOUT   = 1000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED_HI = 2'd1,
        ST_HIGH     = 2'd2,
        ST_LOW      = 2'd3
    } pwm_state_e;

    // Nominal high time for duty step idx of a generator sweep.
    function automatic int unsigned duty_ton(input int unsigned idx);
        return idx * PWM_DUTY_STEP;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input plus rise/fall detect
// on the synchronized level.
module pwm_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              p_q;
    logic              p_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        p_d    = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            p_q    <= 1'b0;
        end else begin
            sync_q <= sync_d;
            p_q    <= p_d;
        end
    end

    assign s    = sync_q[STAGES-1];
    assign rise = s & ~p_q;
    assign fall = ~s & p_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an incoming PWM waveform
// and flags a stalled line.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no live measurement; waiting for the first rise
// ARMED_HI  | first high phase after IDLE; no complete cycle yet
// HIGH      | high phase of a cycle whose predecessor was published
// LOW       | low phase; next rise closes the cycle and publishes
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int          CNT_W       = PWM_CNT_W,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = PWM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] ton,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             no_signal,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pwm_state_e       state_q;
    pwm_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] hi_cnt_d;
    logic [CNT_W-1:0] ton_q;
    logic [CNT_W-1:0] ton_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic             valid_q;
    logic             valid_d;
    logic             no_signal_q;
    logic             no_signal_d;
    logic             level_q;
    logic             level_d;

    logic s;
    logic rise;
    logic fall;
    logic at_limit;
    logic timeout;
    logic publish;
    logic capture_hi;

    pwm_sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_in(pwm_in),
        .s   (s),
        .rise(rise),
        .fall(fall)
    );

    // Saturating at TIMEOUT keeps long gaps from wrapping into a bogus period.
    assign at_limit = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CNT_ONE;
        end else if (!at_limit) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // An edge arriving on the cycle the limit is reached takes precedence.
    assign timeout    = (state_q != ST_IDLE) && at_limit && !rise && !fall;
    assign publish    = (state_q == ST_LOW) && rise;
    assign capture_hi = ((state_q == ST_ARMED_HI) || (state_q == ST_HIGH)) && fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_ARMED_HI;
            end
            ST_ARMED_HI, ST_HIGH: begin
                if (fall)         state_d = ST_LOW;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_LOW: begin
                if (rise)         state_d = ST_HIGH;
                else if (timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hi_cnt_d    = hi_cnt_q;
        ton_d       = ton_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        no_signal_d = no_signal_q;
        level_d     = s;
        if (capture_hi) begin
            hi_cnt_d = cnt_q;
        end
        if (publish) begin
            ton_d       = hi_cnt_q;
            period_d    = cnt_q;
            valid_d     = 1'b1;
            no_signal_d = 1'b0;
        end
        if (timeout) begin
            no_signal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            hi_cnt_q    <= '0;
            ton_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            no_signal_q <= 1'b1;
            level_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            ton_q       <= ton_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            no_signal_q <= no_signal_d;
            level_q     <= level_d;
        end
    end

    assign ton       = ton_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign no_signal = no_signal_q;
    assign level     = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: the driver predicts publishes and
// timeouts from the driven waveform; a monitor compares them as they appear.
module tb_pwm_capture;

    localparam int CNT_W = 16;
    localparam int S     = 2;
    localparam int TO    = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [CNT_W-1:0] ton;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             no_signal;
    logic             level;

    pwm_capture #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(S),
        .TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .ton      (ton),
        .period   (period),
        .valid    (valid),
        .no_signal(no_signal),
        .level    (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_to;
        int t;
        int ton;
        int per;
        bit lvl;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model in terms of driven edge times (cycle of each input change).
    bit m_cur       = 1'b0;
    bit m_have_rise = 1'b0;
    bit m_have_fall = 1'b0;
    int m_r         = 0;
    int m_f         = 0;

    task automatic drive_level(input bit lvl, input int n);
        int  t;
        ev_t e;
        t      = cyc;
        pwm_in = lvl;
        if (lvl != m_cur) begin
            if (lvl) begin
                if (m_have_rise && m_have_fall) begin
                    e = '{1'b0, t + 1 + S, m_f - m_r, t - m_r, 1'b1};
                    q.push_back(e);
                end
                m_have_rise = 1'b1;
                m_have_fall = 1'b0;
                m_r         = t;
            end else if (m_have_rise) begin
                m_have_fall = 1'b1;
                m_f         = t;
            end
            m_cur = lvl;
        end
        if (m_have_rise && ((t + n) - m_r > TO)) begin
            e = '{1'b1, m_r + TO + 1 + S, 0, 0, lvl};
            q.push_back(e);
            m_have_rise = 1'b0;
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        drive_level(1'b1, hi);
        drive_level(1'b0, lo);
    endtask

    bit  prev_ns = 1'b1;
    int  exp_ton = 0;
    int  exp_per = 0;
    ev_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_ns = 1'b1;
            exp_ton = 0;
            exp_per = 0;
        end else begin
            if (valid) begin
                if (q.size() == 0 || q[0].is_to) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1 ton=%0d period=%0d expected no publish (cycle %0d)",
                             ton, period, cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("valid_time", cyc, mon_e.t);
                    chk("ton", int'(ton), mon_e.ton);
                    chk("period", int'(period), mon_e.per);
                    chk("no_signal_at_valid", int'(no_signal), 0);
                    chk("level_at_valid", int'(level), 1);
                    exp_ton = mon_e.ton;
                    exp_per = mon_e.per;
                end
            end
            if (no_signal && !prev_ns) begin
                if (q.size() == 0 || !q[0].is_to) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_no_signal: got no_signal=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("timeout_time", cyc, mon_e.t);
                    chk("timeout_level", int'(level), int'(mon_e.lvl));
                    chk("timeout_valid", int'(valid), 0);
                    chk("timeout_ton_hold", int'(ton), exp_ton);
                    chk("timeout_period_hold", int'(period), exp_per);
                end
            end
            if (!no_signal && prev_ns && !valid) begin
                checks++;
                errors++;
                $display("FAIL no_signal_clear: got no_signal=0 without valid expected 1 (cycle %0d)", cyc);
            end
            prev_ns = no_signal;
        end
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ton", int'(ton), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_no_signal", int'(no_signal), 1);
        chk("rst_level", int'(level), 0);
        rst = 1'b0;

        repeat (5) pulse(10, 40);

        // Duty sweep: the zero-duty step holds low long enough to time out.
        drive_level(1'b0, 300);
        for (int k = 1; k < 10; k++) pulse(5 * k, 50 - 5 * k);

        repeat (20) pulse(1, 1);

        // Rise exactly at the limit publishes; one cycle later times out.
        pulse(10, 40);
        pulse(10, 190);
        pulse(10, 191);
        pulse(10, 40);
        pulse(10, 40);

        // Stall high.
        pulse(10, 40);
        pulse(10, 40);
        drive_level(1'b1, 300);
        drive_level(1'b0, 40);

        // Reset in the middle of a high phase.
        repeat (3) pulse(10, 40);
        drive_level(1'b1, 5);
        rst = 1'b1;
        #1;
        chk("midrst_ton", int'(ton), 0);
        chk("midrst_period", int'(period), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_no_signal", int'(no_signal), 1);
        chk("midrst_level", int'(level), 0);
        chk("pending_before_reset", q.size(), 0);
        q.delete();
        m_have_rise = 1'b0;
        m_have_fall = 1'b0;
        m_cur       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_level(1'b1, 5);
        drive_level(1'b0, 40);
        repeat (3) pulse(10, 40);

        repeat (40) pulse(int'($urandom_range(1, 60)), int'($urandom_range(1, 60)));

        drive_level(1'b0, 400);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
